// File: rtl/mac_seq_ctrl.sv
// Job sequencer for one mac_block: takes a command, streams operand beats into the
// MAC, waits out its output register and returns the result on a valid/ready channel.
module mac_seq_ctrl #(
  parameter int unsigned MIN_W  = 8,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned CONF_W = 3,
  parameter int unsigned LEN_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_mode,
  input  logic                    cmd_acc,
  input  logic [ACC_W-1:0]        cmd_init,
  input  logic [LEN_W-1:0]        cmd_len,
  input  logic                    op_valid,
  output logic                    op_ready,
  input  logic [MIN_W-1:0]        op_a,
  input  logic [MIN_W-1:0]        op_b,
  input  logic [MIN_W-1:0]        op_dual,
  input  logic [MIN_W-1:0]        op_q1,
  input  logic [MIN_W-1:0]        op_q2,
  output logic                    mac_en,
  output logic                    mac_clr,
  output logic [MIN_W-1:0]        mac_a,
  output logic [MIN_W-1:0]        mac_b,
  output logic [MIN_W-1:0]        mac_dual,
  output logic [MIN_W-1:0]        mac_q1,
  output logic [MIN_W-1:0]        mac_q2,
  output logic [ACC_W+CONF_W-1:0] mac_cfg,
  input  logic [ACC_W-1:0]        mac_c,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [ACC_W-1:0]        res_data,
  output logic                    res_err,
  input  logic                    abort,
  output logic                    busy
);

  localparam int unsigned CFG_W = ACC_W + CONF_W;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [CFG_W-1:0] cfg_q, cfg_d;
  logic             err_q, err_d;
  logic [ACC_W-1:0] res_data_q, res_data_d;
  logic [CONF_W-1:0] conf;
  logic             cfg_acc;
  logic [ACC_W-1:0] cfg_init;

  // Config field layout: acc in the top bit, zero padding, mode in the low two bits.
  assign cfg_acc  = cfg_q[CONF_W-1];
  assign cfg_init = cfg_q[CFG_W-1:CONF_W];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cfg_d      = cfg_q;
    err_d      = err_q;
    res_data_d = res_data_q;
    conf       = '0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          conf[1:0]        = (cmd_mode == 2'b11) ? 2'b00 : cmd_mode;
          conf[CONF_W-1]   = cmd_acc;
          cfg_d            = {cmd_init, conf};
          cnt_d            = cmd_len;
          err_d            = (cmd_mode == 2'b11);
          state_d          = S_LOAD;
        end
      end
      S_LOAD: begin
        // Empty job never touches the MAC, so the result is formed here.
        if (cnt_q == '0) begin
          res_data_d = cfg_acc ? cfg_init : '0;
          state_d    = S_DONE;
        end else begin
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        if (op_valid) begin
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        res_data_d = mac_c;
        state_d    = S_DONE;
      end
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Cancel wins over everything; any partial result is dropped.
    if (abort && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      cnt_d      = '0;
      res_data_d = res_data_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cfg_q      <= '0;
      err_q      <= 1'b0;
      res_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cfg_q      <= cfg_d;
      err_q      <= err_d;
      res_data_q <= res_data_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign op_ready  = (state_q == S_RUN);
  assign mac_en    = (state_q == S_RUN) && op_valid && !abort;
  assign mac_clr   = (state_q == S_LOAD);
  assign res_valid = (state_q == S_DONE);
  assign res_data  = res_data_q;
  assign res_err   = err_q;
  assign mac_cfg   = cfg_q;

  // Operands are only presented to the MAC while beats are being streamed.
  assign mac_a    = (state_q == S_RUN) ? op_a    : '0;
  assign mac_b    = (state_q == S_RUN) ? op_b    : '0;
  assign mac_dual = (state_q == S_RUN) ? op_dual : '0;
  assign mac_q1   = (state_q == S_RUN) ? op_q1   : '0;
  assign mac_q2   = (state_q == S_RUN) ? op_q2   : '0;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: behavioural MAC model, directed jobs, scoreboard monitor
// comparing each result handshake against hand-computed expectations.
module tb_mac_seq_ctrl;

  localparam int unsigned MIN_W  = 8;
  localparam int unsigned ACC_W  = 32;
  localparam int unsigned CONF_W = 3;
  localparam int unsigned LEN_W  = 8;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic                    cmd_valid = 1'b0, cmd_ready;
  logic [1:0]              cmd_mode = '0;
  logic                    cmd_acc = 1'b0;
  logic [ACC_W-1:0]        cmd_init = '0;
  logic [LEN_W-1:0]        cmd_len = '0;
  logic                    op_valid = 1'b0, op_ready;
  logic [MIN_W-1:0]        op_a = '0, op_b = '0, op_dual = '0, op_q1 = '0, op_q2 = '0;
  logic                    mac_en, mac_clr;
  logic [MIN_W-1:0]        mac_a, mac_b, mac_dual, mac_q1, mac_q2;
  logic [ACC_W+CONF_W-1:0] mac_cfg;
  logic [ACC_W-1:0]        mac_c;
  logic                    res_valid, res_ready = 1'b1, res_err;
  logic [ACC_W-1:0]        res_data;
  logic                    abort = 1'b0, busy;

  mac_seq_ctrl #(.MIN_W(MIN_W), .ACC_W(ACC_W), .CONF_W(CONF_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode), .cmd_acc(cmd_acc),
    .cmd_init(cmd_init), .cmd_len(cmd_len),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b), .op_dual(op_dual),
    .op_q1(op_q1), .op_q2(op_q2),
    .mac_en(mac_en), .mac_clr(mac_clr), .mac_a(mac_a), .mac_b(mac_b), .mac_dual(mac_dual),
    .mac_q1(mac_q1), .mac_q2(mac_q2), .mac_cfg(mac_cfg), .mac_c(mac_c),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
    .abort(abort), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural MAC: clr loads init, en accumulates or replaces, C is the register.
  logic [ACC_W-1:0] macc;
  logic [ACC_W-1:0] prod;
  assign mac_c = macc;
  always_comb begin
    prod = 32'(mac_a) * 32'(mac_b);
    if (mac_cfg[1:0] != 2'b00) prod = prod + ((32'(mac_dual) * 32'(mac_b)) << 8);
    if (mac_cfg[1:0] == 2'b10)
      prod = prod + ((32'(mac_q1) * 32'(mac_b)) << 16) + ((32'(mac_q2) * 32'(mac_b)) << 24);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         macc <= '0;
    else if (mac_clr) macc <= mac_cfg[ACC_W+CONF_W-1:CONF_W];
    else if (mac_en)  macc <= mac_cfg[CONF_W-1] ? macc + prod : prod;
  end

  typedef struct {
    logic [ACC_W-1:0] data;
    logic             err;
    int               en;
    int               lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: per-job pulse counts, latency, hold stability and result pop.
  int               acc_cyc = 0, en_cnt = 0, clr_cnt = 0;
  bit               seen = 0, hold_pend = 0;
  logic [ACC_W-1:0] hold_data = '0;
  always @(negedge clk) begin
    if (!rst) begin
      en_cnt = 0; clr_cnt = 0; seen = 0; hold_pend = 0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        acc_cyc = cyc; en_cnt = 0; clr_cnt = 0; seen = 0;
      end
      if (mac_en) en_cnt++;
      if (mac_clr) clr_cnt++;
      if (hold_pend) begin
        chk("hold_valid", 64'(res_valid), 64'd1);
        chk("hold_data", 64'(res_data), 64'(hold_data));
      end
      hold_pend = 0;
      if (res_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_res_valid", 64'(res_valid), 64'd0);
        end else begin
          if (!seen) begin
            seen = 1;
            if (exp_q[0].lat != 0) chk("latency", 64'(cyc - acc_cyc), 64'(exp_q[0].lat));
          end
          if (res_ready) begin
            chk("res_data", 64'(res_data), 64'(exp_q[0].data));
            chk("res_err", 64'(res_err), 64'(exp_q[0].err));
            chk("mac_en_count", 64'(en_cnt), 64'(exp_q[0].en));
            chk("mac_clr_count", 64'(clr_cnt), 64'd1);
            void'(exp_q.pop_front());
          end else begin
            hold_pend = 1;
            hold_data = res_data;
          end
        end
      end
    end
  end

  task automatic issue(input logic [1:0] mode, input logic acc, input logic [ACC_W-1:0] init,
                       input logic [LEN_W-1:0] len);
    int n = 0;
    cmd_valid = 1'b1; cmd_mode = mode; cmd_acc = acc; cmd_init = init; cmd_len = len;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    if (!cmd_ready) chk("cmd_accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic expect_res(input logic [ACC_W-1:0] data, input logic err, input int en,
                            input int lat);
    exp_t e;
    e.data = data; e.err = err; e.en = en; e.lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic beat(input logic [MIN_W-1:0] a, input logic [MIN_W-1:0] b,
                      input logic [MIN_W-1:0] d, input logic [MIN_W-1:0] q1,
                      input logic [MIN_W-1:0] q2);
    int n = 0;
    op_valid = 1'b1; op_a = a; op_b = b; op_dual = d; op_q1 = q1; op_q2 = q2;
    @(negedge clk);
    while (!op_ready && n < 100) begin @(negedge clk); n++; end
    if (!op_ready) chk("op_accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    op_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(posedge clk); n++; end
    if (exp_q.size() != 0) chk("result_timeout", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #12;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_outs", 64'({mac_en, mac_clr, op_ready, res_valid, res_err}), 64'd0);
    chk("rst_res_data", 64'(res_data), 64'd0);
    chk("rst_mac_cfg", 64'(mac_cfg), 64'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // single, accumulate, back-to-back beats
    expect_res(32'd37, 1'b0, 3, 6);
    issue(2'b00, 1'b1, 32'd10, 8'd3);
    beat(8'd2, 8'd3, 8'd0, 8'd0, 8'd0);
    beat(8'd4, 8'd5, 8'd0, 8'd0, 8'd0);
    beat(8'd1, 8'd1, 8'd0, 8'd0, 8'd0);
    wait_drain();

    // dual, multiply-only
    expect_res(32'd2575, 1'b0, 1, 4);
    issue(2'b01, 1'b0, 32'd999, 8'd1);
    beat(8'd3, 8'd5, 8'd2, 8'd0, 8'd0);
    wait_drain();

    // empty jobs
    expect_res(32'd100, 1'b0, 0, 0);
    issue(2'b00, 1'b1, 32'd100, 8'd0);
    wait_drain();
    expect_res(32'd0, 1'b0, 0, 0);
    issue(2'b00, 1'b0, 32'd100, 8'd0);
    wait_drain();

    // operand gaps plus result back-pressure
    res_ready = 1'b0;
    expect_res(32'd4, 1'b0, 4, 0);
    issue(2'b00, 1'b1, 32'd0, 8'd4);
    for (int i = 0; i < 4; i++) begin
      beat(8'd1, 8'd1, 8'd0, 8'd0, 8'd0);
      @(posedge clk); #1;
    end
    begin
      int n = 0;
      while (!res_valid && n < 50) begin @(posedge clk); #1; n++; end
      chk("bp_res_valid", 64'(res_valid), 64'd1);
    end
    repeat (5) @(posedge clk);
    #1 res_ready = 1'b1;
    wait_drain();

    // illegal mode behaves as single and flags err
    expect_res(32'd4, 1'b1, 1, 4);
    issue(2'b11, 1'b1, 32'd0, 8'd1);
    beat(8'd2, 8'd2, 8'd7, 8'd7, 8'd7);
    wait_drain();

    // abort after one of three beats, with a beat offered in the abort cycle
    issue(2'b00, 1'b1, 32'd5, 8'd3);
    beat(8'd2, 8'd2, 8'd0, 8'd0, 8'd0);
    op_valid = 1'b1; abort = 1'b1;
    @(negedge clk);
    chk("abort_mac_en", 64'(mac_en), 64'd0);
    @(posedge clk); #1;
    abort = 1'b0; op_valid = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_res_valid", 64'(res_valid), 64'd0);
    chk("abort_cmd_ready", 64'(cmd_ready), 64'd1);
    repeat (10) @(posedge clk);
    #1;

    // reset mid-run
    issue(2'b00, 1'b1, 32'd7, 8'd3);
    beat(8'd3, 8'd3, 8'd0, 8'd0, 8'd0);
    op_valid = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("rstmid_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rstmid_busy", 64'(busy), 64'd0);
    chk("rstmid_ctl", 64'({mac_en, mac_clr, op_ready, res_valid, res_err}), 64'd0);
    chk("rstmid_mac_ops", 64'({mac_a, mac_b, mac_dual, mac_q1, mac_q2}), 64'd0);
    chk("rstmid_res_data", 64'(res_data), 64'd0);
    chk("rstmid_mac_cfg", 64'(mac_cfg), 64'd0);
    op_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // quad, multiply-only: 2 + (6<<8) + (8<<16) + (10<<24)
    expect_res(32'd168297986, 1'b0, 1, 4);
    issue(2'b10, 1'b0, 32'd0, 8'd1);
    beat(8'd1, 8'd2, 8'd3, 8'd4, 8'd5);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
Job sequencer for one mac_block. It accepts a command (mode, accumulate flag, initial value, beat count) over a valid/ready channel. It then streams operand beats into the MAC, drives the MAC's en, clr and cfg inputs, waits out the MAC's one-cycle output register, and returns the result over a valid/ready channel. It sits between the operand-fetch logic and the MAC array tile.

Parameters:
MIN_W, 8, MAC operand width (matches MAC_MIN_WIDTH)
ACC_W, 32, accumulator/result width (matches MAC_ACC_WIDTH)
CONF_W, 3, cfg config field width (matches CONF_WIDTH)
LEN_W, 8, beat-count width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when valid&ready
cmd_mode  in  2  00 single, 01 dual, 10 quad, 11 illegal
cmd_acc  in  1  1 = accumulate, 0 = multiply-only
cmd_init  in  ACC_W  initial accumulator value
cmd_len  in  LEN_W  operand beats in job
op_valid  in  1  operand beat valid
op_ready  out  1  operand beat accepted when valid&ready
op_a, op_b, op_dual, op_q1, op_q2  in  MIN_W each  beat operands
mac_en  out  1  MAC enable, one per accepted beat
mac_clr  out  1  one-cycle pulse to MAC rst; MAC loads init from cfg
mac_a, mac_b, mac_dual, mac_q1, mac_q2  out  MIN_W each  to MAC A/B/dual_in/quad_in1/quad_in2
mac_cfg  out  ACC_W+CONF_W  {init, acc, 0, mode}
mac_c  in  ACC_W  MAC C output
res_valid  out  1  result valid
res_ready  in  1  result consumed when valid&ready
res_data  out  ACC_W  result
res_err  out  1  qualifies res_data; 1 = illegal mode
abort  in  1  synchronous job cancel
busy  out  1  state != IDLE

Behaviour:
- Reset (rst=0, async): state IDLE, counter 0, mac_cfg 0; cmd_ready=1. All other outputs 0, including mac_en, mac_clr, op_ready, res_valid, res_data, res_err and busy.
- States: IDLE, LOAD, RUN, DRAIN, DONE.
- IDLE: cmd_ready=1. On cmd_valid, latch mode/acc/init/len into mac_cfg and the counter, then go to LOAD. Mode 11 is latched as 00 with err=1.
- LOAD: mac_clr=1 for exactly one cycle.
  - len=0 → DONE. res_data = init if acc=1, else 0; MAC not sampled, no mac_en.
  - len≠0 → RUN.
- RUN:
  - op_ready=1.
  - mac_en = op_valid. mac_* operands pass op_* combinationally in RUN and are 0 otherwise.
  - Each handshake decrements the counter. The handshake at count 1 → DRAIN.
  - op_valid gaps stall with mac_en=0; no beat is lost or duplicated.
- DRAIN: exactly one cycle, no mac_en. At the end of the cycle, capture mac_c into res_data, then go to DONE.
- Result semantics:
  - acc=1: init + sum of all beat products.
  - acc=0: product of the final beat only; earlier beat products are discarded.
  - Product per beat:
    - single: a*b
    - dual: a*b + (dual*b << MIN_W)
    - quad: additionally adds (q1*b << 2·MIN_W) + (q2*b << 3·MIN_W)
  - Arithmetic truncates modulo 2^ACC_W.
- DONE: res_valid=1. res_data/res_err are stable until res_ready. On the handshake → IDLE; cmd_ready rises the following cycle (no same-cycle back-to-back).
- mac_cfg is stable from LOAD through DONE and changes only on command accept.
- abort=1 in any non-IDLE state:
  - next cycle IDLE, res_valid=0, result discarded
  - an op handshake in the same cycle is ignored (mac_en forced 0)
  - abort in IDLE has no effect
- Latency: job with len=N and no stalls → res_valid asserted N+3 cycles after command accept (LOAD, N×RUN, DRAIN).
- Reset mid-job: returns to IDLE immediately; no partial result is emitted.

Test Plan:
- Single/acc, init=10, len=3, beats (a,b)=(2,3),(4,5),(1,1) with op_valid held high → three mac_en pulses, res_data=37, res_valid 6 cycles after accept.
- Dual/mult-only, len=1, a=3, dual=2, b=5 → res_data=2575 (15+(10<<8)), res_err=0.
- Single/acc, init=100, len=0 → mac_clr pulse, no mac_en, res_data=100. Same with acc=0 → res_data=0.
- Single/acc, init=0, len=4, all operands (1,1), op_valid toggling 1,0,1,0… → exactly 4 mac_en pulses, res_data=4; res_ready held low 5 cycles → res_valid and res_data=4 stable throughout.
- Mode=11, len=1, a=2, b=2, acc=1, init=0 → res_data=4 (single behaviour), res_err=1.
- Assert abort in RUN after 1 of 3 beats → IDLE next cycle, no res_valid. Repeat with rst=0 mid-RUN → all outputs 0 asynchronously, busy=0, cmd_ready=1.
